// File: rtl/irq_pkg.sv
// Shared definitions for the external interrupt controller.
package irq_pkg;

    // Width of a source ID; ID 0 is reserved for "no interrupt"
    localparam int IRQ_ID_W = 5;

    // Word-aligned register offsets
    localparam logic [3:0] IRQ_PENDING = 4'h0;
    localparam logic [3:0] IRQ_ENABLE  = 4'h4;
    localparam logic [3:0] IRQ_MODE    = 4'h8;
    localparam logic [3:0] IRQ_CLAIM   = 4'hC;

    // Register-port access sequencer states
    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } irq_state_e;

endpackage

// File: rtl/irq_sync_edge.sv
// Two-flop synchronizer for one asynchronous interrupt line, plus a third
// flop so a rising edge of the synchronized level yields a one-cycle pulse.
module irq_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic irq,
    output logic level,
    output logic rise
);

    logic r_sync1;
    logic r_sync2;
    logic r_sync3;

    // Shift the raw line through the synchronizer and the edge-history flop
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
        end else begin
            r_sync1 <= irq;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign level = r_sync2;
    assign rise  = r_sync2 & ~r_sync3;

endmodule

// File: rtl/irq_controller.sv
// External interrupt controller: synchronizes peripheral lines, keeps
// pending/enable/mode/in-service state, drives ext_int and serves a
// word-addressed register port with a claim/complete handshake.
module irq_controller
    import irq_pkg::*;
#(
    parameter int NUM_SOURCES = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_SOURCES-1:0] irq_in,
    input  logic                   enable,
    input  logic                   write,
    input  logic [3:0]             addr,
    input  logic [31:0]            wdata,
    output logic [31:0]            rdata,
    output logic                   busy,
    output logic                   fault,
    output logic                   ext_int
);

    logic [NUM_SOURCES-1:0] r_pending;
    logic [NUM_SOURCES-1:0] r_enable;
    logic [NUM_SOURCES-1:0] r_mode;
    logic [NUM_SOURCES-1:0] r_in_service;
    irq_state_e             r_state;
    logic                   r_write;
    logic [3:0]             r_addr;

    logic [NUM_SOURCES-1:0] w_level;
    logic [NUM_SOURCES-1:0] w_rise;
    logic [NUM_SOURCES-1:0] w_cand;
    logic [IRQ_ID_W-1:0]    w_claim_id;
    logic [NUM_SOURCES-1:0] w_claim_mask;
    logic [NUM_SOURCES-1:0] w_cmp_mask;
    logic [NUM_SOURCES-1:0] w_pend_clr;
    logic [NUM_SOURCES-1:0] w_isv_set;
    logic [NUM_SOURCES-1:0] w_isv_clr;
    logic                   w_misaligned;
    logic                   w_act;
    logic [31:0]            w_rdata;
    logic                   w_unused;

    // Upper wdata bits are ignored by every register
    assign w_unused = ^wdata;

    for (genvar g = 0; g < NUM_SOURCES; g++) begin : g_src
        irq_sync_edge u_sync (
            .clk   (clk),
            .reset (reset),
            .irq   (irq_in[g]),
            .level (w_level[g]),
            .rise  (w_rise[g])
        );
    end

    assign w_cand       = r_pending & r_enable & ~r_in_service;
    assign w_misaligned = (r_addr[1:0] != 2'b00);
    // Side effects happen only on the ACCESS->DONE edge of an aligned access
    assign w_act        = (r_state == ACCESS) && !w_misaligned;

    // Lowest-ID-wins priority encoder plus one-hot decodes for claim/complete
    always_comb begin
        w_claim_id   = '0;
        w_claim_mask = '0;
        w_cmp_mask   = '0;
        for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
            if (w_cand[i]) w_claim_id = IRQ_ID_W'(i + 1);
        end
        // IDs 0 and > NUM_SOURCES decode to an empty mask, so they are ignored
        for (int i = 0; i < NUM_SOURCES; i++) begin
            w_claim_mask[i] = (w_claim_id == IRQ_ID_W'(i + 1));
            w_cmp_mask[i]   = (wdata[IRQ_ID_W-1:0] == IRQ_ID_W'(i + 1));
        end
    end

    // Per-bit clear/set requests generated by the current access
    always_comb begin
        w_pend_clr = '0;
        w_isv_set  = '0;
        w_isv_clr  = '0;
        if (w_act) begin
            if (r_write) begin
                if (r_addr == IRQ_PENDING) w_pend_clr = wdata[NUM_SOURCES-1:0] & r_mode;
                if (r_addr == IRQ_CLAIM)   w_isv_clr  = w_cmp_mask;
            end else if (r_addr == IRQ_CLAIM) begin
                w_isv_set  = w_claim_mask;
                w_pend_clr = w_claim_mask & r_mode;
            end
        end
    end

    // Read data mux; unused upper bits are zero-extended
    always_comb begin
        w_rdata = '0;
        case (r_addr)
            IRQ_PENDING: w_rdata = 32'(r_pending);
            IRQ_ENABLE:  w_rdata = 32'(r_enable);
            IRQ_MODE:    w_rdata = 32'(r_mode);
            IRQ_CLAIM:   w_rdata = 32'(w_claim_id);
            default:     w_rdata = '0;
        endcase
    end

    // Interrupt state: a fresh edge always beats a same-cycle clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pending    <= '0;
            r_enable     <= '0;
            r_mode       <= '0;
            r_in_service <= '0;
            ext_int      <= 1'b0;
        end else begin
            r_pending    <= (~r_mode & w_level) |
                            (r_mode & (w_rise | (r_pending & ~w_pend_clr)));
            r_in_service <= (r_in_service | w_isv_set) & ~w_isv_clr;
            ext_int      <= |w_cand;
            if (w_act && r_write && (r_addr == IRQ_ENABLE)) r_enable <= wdata[NUM_SOURCES-1:0];
            if (w_act && r_write && (r_addr == IRQ_MODE))   r_mode   <= wdata[NUM_SOURCES-1:0];
        end
    end

    // Access sequencer: IDLE -> ACCESS -> DONE, back to IDLE once enable drops
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_write <= 1'b0;
            r_addr  <= '0;
            rdata   <= '0;
            busy    <= 1'b0;
            fault   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (enable) begin
                        r_state <= ACCESS;
                        r_write <= write;
                        r_addr  <= addr;
                        busy    <= 1'b1;
                    end
                end
                ACCESS: begin
                    r_state <= DONE;
                    busy    <= 1'b0;
                    fault   <= w_misaligned;
                    rdata   <= (w_misaligned || r_write) ? '0 : w_rdata;
                end
                DONE: begin
                    if (!enable) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller using an expected-result queue.
module tb_irq_controller;

    localparam int NS = 8;

    logic          clk     = 1'b0;
    logic          reset   = 1'b1;
    logic [NS-1:0] irq_in  = '0;
    logic          enable  = 1'b0;
    logic          write   = 1'b0;
    logic [3:0]    addr    = '0;
    logic [31:0]   wdata   = '0;
    logic [31:0]   rdata;
    logic          busy;
    logic          fault;
    logic          ext_int;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       tag;
        bit          is_rd;
        logic [31:0] rd;
        logic        flt;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    irq_controller #(.NUM_SOURCES(NS)) dut (
        .clk     (clk),
        .reset   (reset),
        .irq_in  (irq_in),
        .enable  (enable),
        .write   (write),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .busy    (busy),
        .fault   (fault),
        .ext_int (ext_int)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // One register access, started and finished on a falling edge
    task automatic op(input logic wr, input logic [3:0] a, input logic [31:0] d,
                      input bit is_rd, input logic [31:0] exp_rd, input string tag);
        exp_t e;
        e.tag   = tag;
        e.is_rd = is_rd;
        e.rd    = exp_rd;
        e.flt   = (a[1:0] != 2'b00);
        sb.push_back(e);
        enable = 1'b1;
        write  = wr;
        addr   = a;
        wdata  = d;
        step(1);
        chk({tag, "_busy_acc"}, 32'(busy), 32'd1);
        step(1);
        chk({tag, "_busy_done"}, 32'(busy), 32'd0);
        if (sb.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            if (e.is_rd) chk(e.tag, rdata, e.rd);
            chk({e.tag, "_fault"}, 32'(fault), 32'(e.flt));
        end
        enable = 1'b0;
        write  = 1'b0;
        step(1);
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string tag);
        op(1'b0, a, 32'd0, 1'b1, exp, tag);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input string tag);
        op(1'b1, a, d, 1'b0, 32'd0, tag);
    endtask

    task automatic pulse0();
        irq_in[0] = 1'b1;
        step(1);
        irq_in[0] = 1'b0;
    endtask

    initial begin
        #2 reset = 1'b0;
        step(2);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ext_int", 32'(ext_int), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        reset = 1'b1;

        rd(4'h0, 32'd0, "rst_pending");
        rd(4'h4, 32'd0, "rst_enable_reg");
        rd(4'h8, 32'd0, "rst_mode");
        rd(4'hC, 32'd0, "rst_claim");

        // Edge-mode source 1: latency to pending and ext_int, then claim
        wr(4'h8, 32'h01, "wr_mode1");
        wr(4'h4, 32'h01, "wr_en1");
        irq_in[0] = 1'b1;
        step(1);
        irq_in[0] = 1'b0;
        chk("ext_k0", 32'(ext_int), 32'd0);
        step(1);
        chk("ext_k1", 32'(ext_int), 32'd0);
        step(1);
        chk("ext_k2", 32'(ext_int), 32'd0);
        step(1);
        chk("ext_k3", 32'(ext_int), 32'd1);
        rd(4'h0, 32'h1, "pend_edge");
        rd(4'hC, 32'd1, "claim_1");
        chk("ext_after_claim", 32'(ext_int), 32'd0);
        rd(4'h0, 32'h0, "pend_after_claim");
        wr(4'hC, 32'd1, "complete_1");

        // Edge -> level switch: pending follows the (low) level
        pulse0();
        step(3);
        rd(4'h0, 32'h1, "pend_edge2");
        wr(4'h8, 32'h00, "wr_mode0");
        rd(4'h0, 32'h0, "pend_follow_lvl");

        // Level sources 3 and 6
        wr(4'h4, 32'hFF, "wr_enff");
        irq_in = 8'h24;
        step(4);
        chk("ext_lvl", 32'(ext_int), 32'd1);
        rd(4'h0, 32'h24, "pend_lvl");
        rd(4'hC, 32'd3, "claim_3");
        rd(4'hC, 32'd6, "claim_6");
        chk("ext_all_isv", 32'(ext_int), 32'd0);
        rd(4'hC, 32'd0, "claim_none");
        wr(4'hC, 32'd3, "complete_3");
        chk("ext_recomplete", 32'(ext_int), 32'd1);
        rd(4'hC, 32'd3, "claim_3_again");

        // Misaligned accesses and ignored complete IDs (3 and 6 in service)
        rd(4'h5, 32'd0, "mis_rd");
        wr(4'h6, 32'h00, "mis_wr");
        rd(4'h4, 32'hFF, "mis_wr_nochg");
        wr(4'hC, 32'd0, "complete_id0");
        wr(4'hC, 32'd9, "complete_id9");
        chk("ext_ignored_cmp", 32'(ext_int), 32'd0);
        rd(4'hC, 32'd0, "claim_after_ign");
        wr(4'hC, 32'd3, "complete_3b");
        wr(4'hC, 32'd6, "complete_6");
        chk("ext_both_back", 32'(ext_int), 32'd1);
        irq_in = '0;
        step(4);
        chk("ext_lvl_drop", 32'(ext_int), 32'd0);
        rd(4'h0, 32'h0, "pend_lvl_drop");

        // New edge coinciding with a W1C of the same bit
        wr(4'h8, 32'h01, "wr_mode1b");
        pulse0();
        step(3);
        irq_in[0] = 1'b1;
        step(1);
        wr(4'h0, 32'h01, "w1c_race");
        rd(4'h0, 32'h1, "race_set_wins");
        wr(4'h0, 32'h01, "w1c_plain");
        rd(4'h0, 32'h0, "w1c_cleared");
        irq_in[0] = 1'b0;

        // Reset in the middle of an ENABLE write
        enable = 1'b1;
        write  = 1'b1;
        addr   = 4'h4;
        wdata  = 32'h0F;
        step(1);
        chk("mid_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        enable = 1'b0;
        write  = 1'b0;
        step(1);
        reset = 1'b1;
        step(1);
        rd(4'h4, 32'h0, "mid_rst_enable");
        rd(4'h8, 32'h0, "mid_rst_mode");
        chk("mid_rst_ext", 32'(ext_int), 32'd0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
